// File: rtl/capture_arbiter.sv
// capture_arbiter: round-robin capture of four ports' result bytes into a 16K-entry memory,
// with per-port 2-deep FIFOs, drop counters and a small host register window.
module capture_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [7:0]  req_data0,
    input  logic [7:0]  req_data1,
    input  logic [7:0]  req_data2,
    input  logic [7:0]  req_data3,
    output logic        wr_en,
    output logic [13:0] wr_addr,
    output logic [9:0]  wr_data,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        halted
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [0:0]  r_state;
    logic [7:0]  r_fifo [4][2];
    logic [1:0]  r_cnt [4];
    logic [7:0]  r_drop [4];
    logic [14:0] r_count;
    logic [1:0]  r_last;
    logic        r_wr_en;
    logic [13:0] r_wr_addr;
    logic [9:0]  r_wr_data;
    logic [7:0]  r_rdata;

    logic [7:0]  w_din [4];
    logic [3:0]  w_ne;
    logic [3:0]  w_pop;
    logic [3:0]  w_acc;
    logic        w_clr;
    logic        w_gnt;
    logic [1:0]  w_gp;
    logic [1:0]  w_idx;
    logic [7:0]  w_rmux;

    assign w_din = '{req_data0, req_data1, req_data2, req_data3};
    assign w_clr = chipselect & write & (address == 3'd0) & writedata[0];

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_port
            assign w_ne[i]  = r_cnt[i] != 2'd0;
            assign w_pop[i] = w_gnt && (w_gp == 2'(i));
            // a full FIFO still takes a byte when its head leaves in the same cycle
            assign w_acc[i] = req_valid[i] && (r_cnt[i] != 2'd2 || w_pop[i]);
        end
    endgenerate

    // descending scan so the port right after the last grant wins
    always_comb begin
        w_gnt = 1'b0;
        w_gp  = 2'd0;
        w_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_last + 2'd1 + 2'(k);
            if (r_state == RUN && w_ne[w_idx]) begin
                w_gnt = 1'b1;
                w_gp  = w_idx;
            end
        end
    end

    assign w_rmux = address[2] ? r_drop[address[1:0]] :
                    address[1:0] == 2'd0 ? {6'b0, r_state == HALT, |w_ne} :
                    address[1:0] == 2'd1 ? r_count[7:0] :
                    address[1:0] == 2'd2 ? {1'b0, r_count[14:8]} : 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_addr <= 14'd0;
            r_wr_data <= 10'd0;
            r_rdata   <= 8'd0;
        end else if (chipselect && read) begin
            r_rdata <= w_rmux;
        end
        if (reset || w_clr) begin
            for (int p = 0; p < 4; p++) begin
                r_cnt[p]  <= 2'd0;
                r_drop[p] <= 8'd0;
            end
            r_count <= 15'd0;
            r_last  <= 2'd3;
            r_state <= RUN;
            r_wr_en <= 1'b0;
        end else begin
            r_wr_en <= w_gnt;
            if (w_gnt) begin
                r_wr_addr <= r_count[13:0];
                r_wr_data <= {w_gp, r_fifo[w_gp][0]};
                r_count   <= r_count + 15'd1;
                r_last    <= w_gp;
                if (r_count == 15'd16383) r_state <= HALT;
            end
            for (int p = 0; p < 4; p++) begin
                r_cnt[p] <= r_cnt[p] - {1'b0, w_pop[p]} + {1'b0, w_acc[p]};
                if (w_pop[p]) r_fifo[p][0] <= r_fifo[p][1];
                if (w_acc[p]) begin
                    if (r_cnt[p] - {1'b0, w_pop[p]} == 2'd0) r_fifo[p][0] <= w_din[p];
                    else r_fifo[p][1] <= w_din[p];
                end
                if (req_valid[p] && !w_acc[p] && r_drop[p] != 8'hFF) r_drop[p] <= r_drop[p] + 8'd1;
            end
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign readdata = r_rdata;
    assign halted   = r_state == HALT;
endmodule

// File: tb/tb_capture_arbiter.sv
// tb_capture_arbiter: randomized and directed stimulus against a queue-based reference model,
// with a scoreboard monitor comparing capture writes and host reads.
module tb_capture_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = 4'd0;
    logic [7:0]  req_data0 = 8'd0, req_data1 = 8'd0, req_data2 = 8'd0, req_data3 = 8'd0;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [2:0]  address = 3'd0;
    logic [7:0]  writedata = 8'd0;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [9:0]  wr_data;
    logic [7:0]  readdata;
    logic        halted;

    capture_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .chipselect(chipselect), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata), .halted(halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          stamp;
        logic [23:0] val;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    exp_t e;
    int n_chk = 0;
    int n_bad = 0;

    // reference model: per-port byte queues and plain counters
    logic [7:0] mq [4][$];
    int  m_drop [4];
    int  m_cnt  = 0;
    int  m_last = 3;
    bit  m_halt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rdval(input logic [2:0] a);
        int ne = 0;
        for (int i = 0; i < 4; i++) if (mq[i].size() > 0) ne = 1;
        case (a)
            3'd0:    return {6'b0, m_halt, ne[0]};
            3'd1:    return 8'(m_cnt);
            3'd2:    return 8'(m_cnt >> 8);
            3'd3:    return 8'd0;
            default: return 8'(m_drop[a - 3'd4]);
        endcase
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            m_drop[i] = 0;
        end
        m_cnt = 0;
        m_last = 3;
        m_halt = 0;
    endtask

    // drives one cycle (called at posedge+2) and advances the model by that cycle
    task automatic step(input logic [3:0] rv, input logic [31:0] d, input logic cs, input logic rd,
                        input logic wr, input logic [2:0] a, input logic [7:0] wd);
        int gp;
        logic clr;
        logic [7:0] b;
        check("halted", halted, m_halt);
        req_valid = rv;
        {req_data3, req_data2, req_data1, req_data0} = d;
        chipselect = cs; read = rd; write = wr; address = a; writedata = wd;
        clr = cs && wr && a == 3'd0 && wd[0];
        if (cs && rd) rq.push_back('{cyc, 24'(rdval(a))});
        gp = -1;
        if (!m_halt)
            for (int k = 1; k <= 4; k++)
                if (gp < 0 && mq[(m_last + k) % 4].size() > 0) gp = (m_last + k) % 4;
        if (clr) m_clear();
        else begin
            if (gp >= 0) begin
                b = mq[gp].pop_front();
                wq.push_back('{cyc, {14'(m_cnt), 2'(gp), b}});
                m_cnt++;
                m_last = gp;
                if (m_cnt == 16384) m_halt = 1;
            end
            for (int i = 0; i < 4; i++)
                if (rv[i]) begin
                    if (mq[i].size() < 2) mq[i].push_back(d[8*i +: 8]);
                    else if (m_drop[i] < 255) m_drop[i]++;
                end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic tick(input logic [3:0] rv, input logic [31:0] d);
        step(rv, d, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(4'd0, 32'd0);
    endtask

    task automatic hread(input logic [2:0] a);
        step(4'd0, 32'd0, 1'b1, 1'b1, 1'b0, a, 8'd0);
    endtask

    task automatic hclear();
        step(4'd0, 32'd0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01);
    endtask

    task automatic read_all();
        for (int a = 0; a < 8; a++) hread(3'(a));
        idle(2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 4'd0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        m_clear();
        @(posedge clk);
        #2;
        reset = 1'b0;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_readdata", readdata, 0);
    endtask

    // scoreboard monitor: writes must appear exactly one cycle after their grant
    always @(negedge clk) begin
        if (wr_en) begin
            check("wr_pending", wq.size() > 0, 1);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                check("wr_cycle", cyc, e.stamp + 1);
                check("wr_word", {8'd0, wr_addr, wr_data}, {8'd0, e.val});
            end
        end else if (wq.size() > 0 && wq[0].stamp + 1 == cyc) begin
            check("missing_wr", wr_en, 1);
            void'(wq.pop_front());
        end
        if (rq.size() > 0 && rq[0].stamp + 1 == cyc) begin
            e = rq.pop_front();
            check("readdata", readdata, e.val);
        end
    end

    initial begin
        int r;
        int n;
        #2;
        do_reset();
        read_all();
        // single port
        tick(4'b0001, 32'h0000005A);
        idle(3);
        hread(3'd1);
        idle(2);
        // contention
        tick(4'b1111, 32'h13121110);
        idle(6);
        // overflow on port 2 while port 0 stays busy
        for (int i = 0; i < 8; i++) tick({1'b0, i < 4, 1'b0, 1'b1}, $urandom);
        idle(8);
        hread(3'd6);
        idle(2);
        // drop-counter saturation
        for (int i = 0; i < 400; i++) tick(4'b1111, $urandom);
        idle(10);
        read_all();
        // grant coinciding with clear
        tick(4'b0001, 32'h00000077);
        hclear();
        idle(3);
        read_all();
        // random traffic with host accesses
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5) step(4'($urandom), $urandom, 1'b1, 1'b1, 1'b0, 3'($urandom_range(0, 7)), 8'd0);
            else if (r < 6) step(4'($urandom), $urandom, 1'b1, 1'b0, 1'b1, 3'd0, 8'h01);
            else if (r < 8) step(4'($urandom), $urandom, 1'b1, 1'b0, 1'b1, 3'($urandom_range(1, 7)), 8'($urandom));
            else if (r < 9) step(4'($urandom), $urandom, 1'b1, 1'b0, 1'b1, 3'd0, 8'($urandom) & 8'hFE);
            else if (r < 10) step(4'($urandom), $urandom, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01);
            else tick(4'($urandom), $urandom);
        end
        idle(10);
        read_all();
        // fill the capture memory
        n = 0;
        while (!m_halt && n < 20000) begin
            tick(4'b1111, $urandom);
            n++;
        end
        idle(4);
        read_all();
        for (int i = 0; i < 10; i++) tick(4'b1111, $urandom);
        idle(4);
        read_all();
        // clear while halted
        hclear();
        idle(1);
        read_all();
        tick(4'b1111, $urandom);
        idle(8);
        read_all();
        // reset with FIFOs non-empty
        tick(4'b1111, $urandom);
        tick(4'b1111, $urandom);
        tick(4'b1111, $urandom);
        do_reset();
        idle(5);
        read_all();
        idle(3);
        check("drain_wr", wq.size(), 0);
        check("drain_rd", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/capture_arbiter.md
CAPTURE_ARBITER -- requirements
Module: capture_arbiter

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  4  per-port "result present" strobe; bit i = switch output port i.
- req_data0..req_data3  in  8 each  result byte of port i, sampled when req_valid[i]=1.
- wr_en  out  1  capture-memory write strobe.
- wr_addr  out  14  capture-memory write address.
- wr_data  out  10  {port[1:0], data[7:0]} written to capture memory.
- chipselect, read, write  in  1 each  host bus qualifiers.
- address  in  3  host register select.
- writedata  in  8  host write data.
- readdata  out  8  host read data.
- halted  out  1  high while capture is stopped on full.

Function
REQ-002 SHALL give each port a 2-entry FIFO (8-bit entries).
REQ-003 SHALL accept req_valid[i] when port-i occupancy < 2, or when port i is granted in the same cycle; otherwise the byte is dropped.
REQ-004 SHALL increment an 8-bit per-port drop counter on each dropped byte, saturating at 255.
REQ-005 SHALL have state machine RUN / HALT.
- RUN: grants allowed.
- HALT: no grants; FIFOs still fill, and overflow still drops and counts.
REQ-006 SHALL, in RUN, grant at most one non-empty FIFO per cycle, round-robin.
- Search starts at the port after the last granted port.
- After reset or clear, port 0 has highest priority.
REQ-007 SHALL dequeue the granted FIFO head in the grant cycle.
- Next cycle: wr_en=1, wr_data={granted port, head byte}, wr_addr=current capture count[13:0].
- Otherwise wr_en=0.
REQ-008 SHALL keep a 15-bit capture count, incremented on every write.
- The write that makes the count reach 16384 SHALL move the FSM to HALT in the same edge.
- The count SHALL not wrap.
REQ-009 SHALL meet these latencies:
- req_valid into an empty, uncontended port at cycle N: grant at N+1, wr_en at N+2.
- Bytes of one port SHALL be written in arrival order.
REQ-010 SHALL register host reads: readdata is valid on the cycle after chipselect&read.
- addr 0 = {6'b0, halted, any FIFO non-empty}
- addr 1 = count[7:0]
- addr 2 = {1'b0, count[14:8]}
- addr 4..7 = drop counters 0..3
- addr 3 = 0
- readdata SHALL hold its value when not reading.
REQ-011 SHALL perform a clear on chipselect&write with address=0 and writedata[0]=1. Clear = count 0, drop counters 0, FIFOs flushed, priority pointer to port 0, FSM to RUN.
- Clear SHALL take effect at that edge; req_valid in the clear cycle is discarded and not counted.
REQ-012 SHALL ignore host writes to any other address or data.
REQ-013 SHALL drive halted high exactly in HALT.
REQ-014 SHALL, if a grant and a clear coincide, suppress the pending write (wr_en=0 next cycle).

Reset
REQ-015 SHALL, on reset=1 at a clock edge, apply the clear of REQ-011 and also set wr_en=0, wr_addr=0, wr_data=0, readdata=0, halted=0.
REQ-016 SHALL let reset asserted mid-capture abort any pending write; no wr_en in the cycle after reset.

Verification
REQ-017 SHALL cover these directed scenarios (stimulus -> required response):
- Single port: req_valid=0001, req_data0=0x5A at cycle N, others idle -> wr_en at N+2, wr_data=0x05A, wr_addr=0; read addr 1 -> 0x01.
- Contention: req_valid=1111 for 1 cycle, data 0x10/0x11/0x12/0x13 -> four writes on consecutive cycles, wr_data 0x010, 0x111, 0x212, 0x313, wr_addr 0..3.
- Overflow: port 2 strobed 4 consecutive cycles while port 0 is kept continuously non-empty -> port 2 writes interleave with port 0; drop count 2 (addr 6) equals strobes minus accepted; saturation after 300 drops reads 255.
- Full: 16384 writes -> halted=1 after the last write; addr 2 = 0x40, addr 1 = 0x00; further req_valid -> no wr_en and drops counted.
- Clear: host write addr 0, data 0x01 while halted -> halted=0, addr 1/2 read 0, drop counters 0, next byte written at wr_addr 0 from port-0 priority.
- Reset mid-operation: reset with FIFOs non-empty -> no wr_en in following cycles until new req_valid; all host reads return 0.
